// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and result flag bundle
package alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational W-bit carry slice used by each pipeline stage
module add_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - STAGES-deep pipelined N-bit adder/subtractor with valid/ready
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int N      = 64,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int W = N / STAGES;

  logic w_en;
  logic w_accept;
  logic w_out_valid;

  // The whole pipeline advances together; a held output freezes every stage.
  assign w_en     = !w_out_valid || out_ready;
  assign in_ready = w_en && rst_n;
  assign w_accept = in_valid && in_ready;

  if (STAGES < 1 || N < 2 || (N % STAGES) != 0) begin : g_param_check
    $error("pipelined_add_sub: requires N >= 2, STAGES >= 1 and N divisible by STAGES");
  end

  // Stage k consumes the lowest remaining operand slice; operands are carried
  // in a shrinking frame so the slice of interest always sits at [W-1:0].
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = N - k * W;

    logic [RW-1:0] w_a_i;
    logic [RW-1:0] w_b_i;
    logic [N-1:0]  w_s_i;
    logic [N-1:0]  w_s_o;
    logic [N-1:0]  w_slice_ext;
    logic          w_c_i;
    logic          w_v_i;
    logic [W-1:0]  w_slice;
    logic          w_cout;
    logic [N-1:0]  r_s;
    logic          r_v;

    if (k == 0) begin : g_head
      assign w_a_i = a;
      assign w_b_i = (op_t'(op) == OP_SUB) ? ~b : b;
      assign w_s_i = '0;
      assign w_c_i = c_in;
      assign w_v_i = w_accept;
    end else begin : g_body
      assign w_a_i = g_stage[k-1].g_fwd.r_a;
      assign w_b_i = g_stage[k-1].g_fwd.r_b;
      assign w_s_i = g_stage[k-1].r_s;
      assign w_c_i = g_stage[k-1].g_fwd.r_c;
      assign w_v_i = g_stage[k-1].r_v;
    end

    add_slice #(.W(W)) u_add_slice (
      .a    (w_a_i[W-1:0]),
      .b    (w_b_i[W-1:0]),
      .cin  (w_c_i),
      .s    (w_slice),
      .cout (w_cout)
    );

    // Lower completed slices pass through; this stage fills in slice k.
    assign w_slice_ext = N'(w_slice);
    assign w_s_o       = w_s_i | (w_slice_ext << (k * W));

    // Partial sum and valid bit advance only on the global enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s <= '0;
        r_v <= 1'b0;
      end else if (w_en) begin
        r_s <= w_s_o;
        r_v <= w_v_i;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-W-1:0] r_a;
      logic [RW-W-1:0] r_b;
      logic            r_c;

      // Forward the unprocessed upper operand slices and the slice carry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
          r_c <= 1'b0;
        end else if (w_en) begin
          r_a <= w_a_i[RW-1:W];
          r_b <= w_b_i[RW-1:W];
          r_c <= w_cout;
        end
      end
    end else begin : g_tail
      alu_flags_t w_flags;
      alu_flags_t r_flags;

      // Here w_a_i/w_b_i hold only the top slice, so bit W-1 is the operand MSB.
      assign w_flags.c_out = w_cout;
      assign w_flags.ovf   = (w_a_i[W-1] == w_b_i[W-1]) && (w_s_o[N-1] != w_a_i[W-1]);
      assign w_flags.zero  = ~|w_s_o;

      // Flags are registered alongside the final partial sum to stay aligned.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_flags <= '0;
        end else if (w_en) begin
          r_flags <= w_flags;
        end
      end
    end
  end

  assign w_out_valid = g_stage[STAGES-1].r_v;
  assign out_valid   = w_out_valid;
  assign sum         = g_stage[STAGES-1].r_s;
  assign c_out       = g_stage[STAGES-1].g_tail.r_flags.c_out;
  assign ovf         = g_stage[STAGES-1].g_tail.r_flags.ovf;
  assign zero        = g_stage[STAGES-1].g_tail.r_flags.zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - self-checking bench for pipelined_add_sub against an arithmetic model
module tb_pipelined_add_sub;

  localparam int N      = 64;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         zero;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  logic held     = 1'b0;
  logic [66:0] held_val = '0;
  logic last_acc = 1'b0;
  logic last_ov  = 1'b0;
  logic last_ir  = 1'b0;

  pipelined_add_sub #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t ref_model(input logic [N-1:0] x, input logic [N-1:0] y,
                                     input logic ci, input logic o);
    exp_t         e;
    logic [N-1:0] yy;
    logic [N:0]   full;
    yy   = o ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + (N+1)'(ci);
    e.s  = full[N-1:0];
    e.c  = full[N];
    e.v  = (x[N-1] == yy[N-1]) && (e.s[N-1] != x[N-1]);
    e.z  = (e.s == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One cycle: drive after the falling edge, observe, then advance past the rising edge.
  task automatic step(input logic v, input logic [N-1:0] aa, input logic [N-1:0] bb,
                      input logic cc, input logic oo, input logic rdy);
    exp_t e;
    in_valid  = v;
    a         = aa;
    b         = bb;
    c_in      = cc;
    op        = oo;
    out_ready = rdy;
    #1;
    last_ov = out_valid;
    last_ir = in_ready;
    if (held) begin
      chk("hold_valid", 72'(out_valid), 72'(1));
      chk("hold_data", 72'({sum, c_out, ovf, zero}), 72'(held_val));
    end
    held     = out_valid && !rdy;
    held_val = {sum, c_out, ovf, zero};
    if (out_valid && rdy) begin
      if (q.size() == 0) begin
        chk("spurious_out", 72'(out_valid), 72'(0));
      end else begin
        e = q.pop_front();
        chk("sum", 72'(sum), 72'(e.s));
        chk("c_out", 72'(c_out), 72'(e.c));
        chk("ovf", 72'(ovf), 72'(e.v));
        chk("zero", 72'(zero), 72'(e.z));
      end
    end
    last_acc = v && in_ready;
    if (last_acc) q.push_back(ref_model(aa, bb, cc, oo));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), rdy);
  endtask

  task automatic latency(input logic [N-1:0] aa, input logic [N-1:0] bb,
                         input logic cc, input logic oo);
    int n;
    step(1'b1, aa, bb, cc, oo, 1'b1);
    chk("lat_accept", 72'(last_acc), 72'(1));
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      idle(1'b1);
      if (last_ov) begin
        n = i;
        break;
      end
    end
    chk("latency", 72'(n), 72'(STAGES));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (q.size() > 0 && cyc < 30) begin
      idle(1'b1);
      cyc++;
    end
    chk("drain_empty", 72'(q.size()), 72'(0));
  endtask

  initial begin
    logic [N-1:0] va [8];
    logic [N-1:0] vb [8];
    logic         vc [8];
    logic         vo [8];
    int           idx;
    int           cyc;
    int           stall_cnt;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    op        = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_in_ready", 72'(in_ready), 72'(0));
    chk("rst_outputs", 72'({sum, c_out, ovf, zero}), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 72'(in_ready), 72'(1));
    @(negedge clk);

    latency(64'h0, 64'h0, 1'b0, 1'b0);
    latency(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    latency(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    latency(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    latency(64'd5, 64'd3, 1'b1, 1'b1);
    latency(64'd3, 64'd5, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
      vo[i] = 1'($urandom);
      vc[i] = vo[i] ? 1'b1 : 1'($urandom);
    end
    idx       = 0;
    cyc       = 0;
    stall_cnt = 0;
    while (idx < 8 && cyc < 50) begin
      step(1'b1, va[idx], vb[idx], vc[idx], vo[idx], !(cyc >= 4 && cyc < 7));
      if (cyc >= 4 && cyc < 7) begin
        chk("bp_in_ready_stall", 72'(last_ir), 72'(0));
        stall_cnt++;
      end
      if (last_acc) idx++;
      cyc++;
    end
    chk("bp_all_accepted", 72'(idx), 72'(8));
    chk("bp_stall_cycles", 72'(stall_cnt), 72'(3));
    drain();

    for (int i = 0; i < 60; i++) begin
      step(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
           1'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();

    for (int i = 0; i < 4; i++) begin
      step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 72'(out_valid), 72'(0));
    chk("midrst_outputs", 72'({sum, c_out, ovf, zero}), 72'(0));
    chk("midrst_in_ready", 72'(in_ready), 72'(0));
    q.delete();
    held = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      chk("midrst_no_stale", 72'(last_ov), 72'(0));
    end
    latency({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
